// File: rtl/hazard_ctl.sv
// hazard_ctl: pipeline sequencing controller for a 5-stage IF/ID/EX/MEM/WB core.
// Tracks destination registers through EX, MEM and WB. From them it produces
// stall, flush and bubble controls and the EX operand-forwarding selects. The
// whole pipeline freezes while a data-memory access waits on mem_ready.
//
// Handshake: the MEM stage raises mem_req for a load/store. The access
// completes in the cycle where mem_req (or a wait already in progress) meets
// mem_ready=1. Each cycle that ends without mem_ready is a wait cycle, and
// all pipeline enables are held low during it.
//
// Optional feature: defining HAZARD_PERF_EN adds the saturating 16-bit
// performance counters stall_cnt, flush_cnt and wait_cnt.
//
// dbg_state exposes the FSM state (0 = RUN, 1 = MEM_WAIT).
module hazard_ctl #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       id_regdst,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       stage_we,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_timeout,
`ifdef HAZARD_PERF_EN
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] wait_cnt,
`endif
  output logic       dbg_state
);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tmo_q, tmo_d;

  // EX shadow
  logic       ex_valid_q, ex_rw_q, ex_mr_q;
  logic [4:0] ex_dest_q, ex_rs_q, ex_rt_q;
  // MEM shadow
  logic       mem_valid_q, mem_rw_q;
  logic [4:0] mem_dest_q;
  // WB shadow
  logic       wb_valid_q, wb_rw_q;
  logic [4:0] wb_dest_q;

  logic [4:0] id_dest;
  logic       load_use;
  logic       go;          // pipeline advances this cycle (not frozen by memory)
  logic       stall_fire;  // a load-use stall is taken this cycle

  assign id_dest   = id_regdst ? id_rd : id_rt;
  assign dbg_state = (state_q == S_MEM_WAIT);

  // Load in EX whose result the ID instruction needs; register 0 never counts
  always_comb begin
    load_use = 1'b0;
    if (ex_valid_q && ex_mr_q && (ex_dest_q != 5'd0)) begin
      load_use = (ex_dest_q == id_rs) || (id_uses_rt && (ex_dest_q == id_rt));
    end
  end

  // FSM next-state, wait counter and pipeline control outputs
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    tmo_d       = tmo_q;
    go          = 1'b0;
    stall_fire  = 1'b0;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stage_we    = 1'b0;

    case (state_q)
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = S_MEM_WAIT;
          wait_d  = WAIT_ONE;
          if (wait_d == WAIT_MAX) tmo_d = 1'b1;
        end else begin
          go = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          // Release cycle: evaluated exactly like a normal RUN cycle
          state_d = S_RUN;
          wait_d  = '0;
          go      = 1'b1;
        end else begin
          wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_ONE;
          if (wait_d == WAIT_MAX) tmo_d = 1'b1;
        end
      end
      default: begin
        state_d = S_RUN;
        wait_d  = '0;
      end
    endcase

    if (go) begin
      if (ex_branch_taken) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        stage_we    = 1'b1;
      end else if (load_use) begin
        stall_fire  = 1'b1;
        idex_bubble = 1'b1;
        stage_we    = 1'b1;
      end else if (id_jump) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b1;
        stage_we    = 1'b1;
      end else begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        stage_we    = 1'b1;
      end
    end

    // Reset drains the pipeline with NOPs and holds the PC
    if (rst) begin
      stall_fire  = 1'b0;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      stage_we    = 1'b1;
    end
  end

  // Operand forwarding: EX/MEM result wins over MEM/WB; register 0 is never forwarded
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (mem_valid_q && mem_rw_q && (mem_dest_q != 5'd0) && (mem_dest_q == ex_rs_q)) begin
        fwd_a = 2'b10;
      end else if (wb_valid_q && wb_rw_q && (wb_dest_q != 5'd0) && (wb_dest_q == ex_rs_q)) begin
        fwd_a = 2'b01;
      end
      if (mem_valid_q && mem_rw_q && (mem_dest_q != 5'd0) && (mem_dest_q == ex_rt_q)) begin
        fwd_b = 2'b10;
      end else if (wb_valid_q && wb_rw_q && (wb_dest_q != 5'd0) && (wb_dest_q == ex_rt_q)) begin
        fwd_b = 2'b01;
      end
    end
  end

  assign mem_timeout = tmo_q && !rst;

  // FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  // Stage shadows advance together with the pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      ex_dest_q   <= 5'd0;
      ex_rs_q     <= 5'd0;
      ex_rt_q     <= 5'd0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_dest_q  <= 5'd0;
      wb_valid_q  <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_dest_q   <= 5'd0;
    end else if (stage_we) begin
      if (idex_bubble) begin
        ex_valid_q <= 1'b0;
        ex_rw_q    <= 1'b0;
        ex_mr_q    <= 1'b0;
        ex_dest_q  <= 5'd0;
        ex_rs_q    <= 5'd0;
        ex_rt_q    <= 5'd0;
      end else begin
        ex_valid_q <= 1'b1;
        ex_rw_q    <= id_regwrite;
        ex_mr_q    <= id_memread;
        ex_dest_q  <= id_dest;
        ex_rs_q    <= id_rs;
        ex_rt_q    <= id_rt;
      end
      mem_valid_q <= ex_valid_q;
      mem_rw_q    <= ex_rw_q;
      mem_dest_q  <= ex_dest_q;
      wb_valid_q  <= mem_valid_q;
      wb_rw_q     <= mem_rw_q;
      wb_dest_q   <= mem_dest_q;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  // Saturating event counters for load-use stalls, front-end flushes and memory waits
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
      wait_cnt_q  <= 16'd0;
    end else begin
      if (stall_fire && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (ifid_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
      if ((state_q == S_MEM_WAIT) && (wait_cnt_q != 16'hFFFF)) wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: directed test-plan steps followed by random traffic. Every
// cycle is checked against a reference model that holds the in-flight
// instructions as a three-entry array (EX, MEM, WB).
module tb_hazard_ctl;

  localparam int MAX_WAIT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_regdst, id_regwrite, id_memread, id_uses_rt, id_jump;
  logic       ex_branch_taken, mem_req, mem_ready;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, stage_we, mem_timeout, dbg_state;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  hazard_ctl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .stage_we(stage_we),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
`ifdef HAZARD_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic [4:0] rs;
    logic [4:0] rt;
  } instr_t;

  instr_t pipe [3];          // 0 = EX, 1 = MEM, 2 = WB
  bit     waiting;           // a memory access is outstanding
  int     wait_run;          // consecutive cycles ended without mem_ready
  bit     tmo;
  int     m_stall, m_flush, m_wait;

  // expected values for the current cycle
  logic       e_pc, e_ifid, e_flush, e_bub, e_stage, e_tmo, e_stall;
  logic [1:0] e_fa, e_fb;
  bit         frozen;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  function automatic logic [1:0] fsel(input logic [4:0] src);
    if (pipe[1].v && pipe[1].rw && pipe[1].dest != 0 && pipe[1].dest == src) return 2'b10;
    if (pipe[2].v && pipe[2].rw && pipe[2].dest != 0 && pipe[2].dest == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic predict();
    bit lu;
    lu = pipe[0].v && pipe[0].mr && pipe[0].dest != 0 &&
         (pipe[0].dest == id_rs || (id_uses_rt && pipe[0].dest == id_rt));
    frozen  = !rst && (waiting ? !mem_ready : (mem_req && !mem_ready));
    e_stall = 1'b0;
    e_fa    = rst ? 2'b00 : fsel(pipe[0].rs);
    e_fb    = rst ? 2'b00 : fsel(pipe[0].rt);
    e_tmo   = rst ? 1'b0 : tmo;
    if (rst) begin
      {e_pc, e_ifid, e_stage, e_flush, e_bub} = 5'b00111;
    end else if (frozen) begin
      {e_pc, e_ifid, e_stage, e_flush, e_bub} = 5'b00000;
    end else if (ex_branch_taken) begin
      {e_pc, e_ifid, e_stage, e_flush, e_bub} = 5'b11111;
    end else if (lu) begin
      {e_pc, e_ifid, e_stage, e_flush, e_bub} = 5'b00101;
      e_stall = 1'b1;
    end else if (id_jump) begin
      {e_pc, e_ifid, e_stage, e_flush, e_bub} = 5'b11110;
    end else begin
      {e_pc, e_ifid, e_stage, e_flush, e_bub} = 5'b11100;
    end
  endtask

  task automatic advance();
    instr_t n;
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      waiting = 0; wait_run = 0; tmo = 0;
      m_stall = 0; m_flush = 0; m_wait = 0;
      return;
    end
    if (waiting && m_wait < 16'hFFFF) m_wait++;
    if (e_stall && m_stall < 16'hFFFF) m_stall++;
    if (e_flush && m_flush < 16'hFFFF) m_flush++;
    if (frozen) begin
      waiting = 1; wait_run++;
      if (wait_run >= MAX_WAIT) tmo = 1;
    end else begin
      waiting = 0; wait_run = 0;
    end
    if (e_stage) begin
      n = '0;
      if (!e_bub) begin
        n.v = 1; n.rw = id_regwrite; n.mr = id_memread;
        n.dest = id_regdst ? id_rd : id_rt;
        n.rs = id_rs; n.rt = id_rt;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = n;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // One clock: inputs are already driven; check just after the falling edge, then clock
  task automatic tick(input string tag);
    #1;
    predict();
    chk({tag, ":pc_we"}, 16'(pc_we), 16'(e_pc));
    chk({tag, ":ifid_we"}, 16'(ifid_we), 16'(e_ifid));
    chk({tag, ":ifid_flush"}, 16'(ifid_flush), 16'(e_flush));
    chk({tag, ":idex_bubble"}, 16'(idex_bubble), 16'(e_bub));
    chk({tag, ":stage_we"}, 16'(stage_we), 16'(e_stage));
    chk({tag, ":fwd_a"}, 16'(fwd_a), 16'(e_fa));
    chk({tag, ":fwd_b"}, 16'(fwd_b), 16'(e_fb));
    chk({tag, ":mem_timeout"}, 16'(mem_timeout), 16'(e_tmo));
    chk({tag, ":state"}, 16'(dbg_state), 16'(waiting));
`ifdef HAZARD_PERF_EN
    chk({tag, ":stall_cnt"}, stall_cnt, 16'(m_stall));
    chk({tag, ":flush_cnt"}, flush_cnt, 16'(m_flush));
    chk({tag, ":wait_cnt"}, wait_cnt, 16'(m_wait));
`endif
    @(posedge clk);
    advance();
    @(negedge clk);
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_id(input int rs, input int rt, input int rd, input bit regdst,
                        input bit rw, input bit mr, input bit ur, input bit jmp);
    id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_regdst = regdst; id_regwrite = rw; id_memread = mr;
    id_uses_rt = ur; id_jump = jmp;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    waiting = 0; wait_run = 0; tmo = 0;
    m_stall = 0; m_flush = 0; m_wait = 0;
    rst = 1; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    nop();
    @(negedge clk);
    tick("reset0");
    tick("reset1");
    rst = 0;
    tick("post_reset");

    // load-use: lw $2 then add $5,$2,$4
    set_id(1, 2, 0, 0, 1, 1, 0, 0); tick("lw2");
    set_id(2, 4, 5, 1, 1, 0, 1, 0); tick("lu_stall");
    tick("lu_release");
    nop();                          tick("lu_fwd_wb");
    tick("lu_drain");

    // back-to-back ALU: add $3 ; sub reads $3,$3
    set_id(1, 1, 3, 1, 1, 0, 1, 0); tick("add3");
    set_id(3, 3, 6, 1, 1, 0, 1, 0); tick("sub33");
    nop();                          tick("fwd_mem");
    // with an intervening NOP
    set_id(1, 1, 3, 1, 1, 0, 1, 0); tick("add3b");
    nop();                          tick("gap");
    set_id(3, 3, 6, 1, 1, 0, 1, 0); tick("sub33b");
    nop();                          tick("fwd_wb");
    // destination $0 never forwards
    set_id(1, 1, 0, 1, 1, 0, 1, 0); tick("add0");
    set_id(0, 0, 6, 1, 1, 0, 1, 0); tick("sub00");
    nop();                          tick("fwd_zero");

    // branch taken alongside a load-use hazard
    set_id(1, 2, 0, 0, 1, 1, 0, 0); tick("lw2b");
    set_id(2, 4, 5, 1, 1, 0, 1, 0);
    ex_branch_taken = 1;            tick("br_over_lu");
    ex_branch_taken = 0; nop();     tick("br_after");

    // jump in ID
    set_id(0, 0, 0, 1, 0, 0, 0, 1); tick("jump");
    nop();                          tick("jump_after");

    // short memory wait (3 cycles), branch ignored while waiting
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      ex_branch_taken = (i == 1);
      tick("wait3");
    end
    ex_branch_taken = 1; mem_ready = 1; tick("wait3_release");
    ex_branch_taken = 0; mem_req = 0;  tick("wait3_done");

    // long memory wait (20 cycles) -> sticky timeout
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 20; i++) tick("wait20");
    mem_ready = 1; tick("wait20_release");
    mem_req = 0; mem_ready = 0;
    tick("tmo_sticky0");
    tick("tmo_sticky1");

    // reset while waiting
    mem_req = 1;
    tick("rw_enter");
    tick("rw_wait");
    rst = 1; tick("rw_reset");
    rst = 0; mem_req = 0; tick("rw_after");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0));
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      mem_req   = ($urandom_range(0, 4) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
